// File: rtl/tick_timer_pkg.sv
// Shared types and defaults for the tick-driven interval timer.
package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } tick_timer_state_e;

  localparam int TICK_TIMER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counting timer consuming a terminal-count tick; pulses done_o on expiry.
// Optional TICK_TIMER_AUTORELOAD_EN: restart the interval from the latched load value on expiry.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int Width = TICK_TIMER_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [Width-1:0] load_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] q_o
);

  localparam logic [Width-1:0] ONE  = Width'(1);
  localparam logic [Width-1:0] ZERO = Width'(0);

  tick_timer_state_e state_r, state_s;
  logic [Width-1:0]  q_r, q_s;
  logic              busy_r, done_r, done_s;
`ifdef TICK_TIMER_AUTORELOAD_EN
  logic [Width-1:0]  reload_r, reload_s;
`endif

  // Next-state, next-count and expiry-pulse decode.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    done_s  = 1'b0;
`ifdef TICK_TIMER_AUTORELOAD_EN
    reload_s = reload_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
`ifdef TICK_TIMER_AUTORELOAD_EN
          reload_s = load_i;
`endif
          q_s = load_i;
          if (load_i == ZERO) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
          q_s     = ZERO;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_s = IDLE;
          q_s     = ZERO;
        end else if (tick_i) begin
          if (q_r > ONE) begin
            q_s = q_r - ONE;
          end else begin
            // Expiry: q_r==1 here; saturate at zero rather than wrap.
            done_s  = 1'b1;
            q_s     = ZERO;
            state_s = DONE;
`ifdef TICK_TIMER_AUTORELOAD_EN
            if (reload_r != ZERO) begin
              q_s     = reload_r;
              state_s = RUN;
            end else begin
              state_s = DONE;
            end
`endif
          end
        end else begin
          q_s = q_r;
        end
      end
      default: begin
        state_s = IDLE;
        q_s     = ZERO;
      end
    endcase
  end

  // State, count and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      q_r     <= ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      busy_r  <= (state_s == RUN);
      done_r  <= done_s;
    end
  end

`ifdef TICK_TIMER_AUTORELOAD_EN
  // Reload value captured with each accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reload_r <= ZERO;
    end else begin
      reload_r <= reload_s;
    end
  end
`endif

  assign busy_o = busy_r;
  assign done_o = done_r;
  assign q_o    = q_r;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios plus randomized traffic against an interval model.
module tb_tick_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] load = 8'd0;
  logic       busy, done;
  logic [7:0] q;

  int n_cmp = 0;
  int n_bad = 0;

  // Interval model: an active interval with remaining ticks, plus a one-cycle done flag.
  bit m_valid = 1'b0;
  bit m_act   = 1'b0;
  bit m_done  = 1'b0;
  int m_rem   = 0;
  int m_reload = 0;

  tick_timer #(.Width(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_i (tick),
    .start_i(start),
    .abort_i(abort),
    .load_i (load),
    .busy_o (busy),
    .done_o (done),
    .q_o    (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Advance the model on every edge, then compare all outputs shortly after it.
  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0; m_rem = 0; m_done = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_act) begin
        m_done = 1'b0;
        if (abort) begin
          m_act = 1'b0; m_rem = 0;
        end else if (tick) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_done = 1'b1;
            m_act  = 1'b0;
`ifdef TICK_TIMER_AUTORELOAD_EN
            if (m_reload != 0) begin
              m_rem = m_reload; m_act = 1'b1;
            end
`endif
          end
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          m_reload = int'(load);
          m_rem    = int'(load);
          if (load == 8'd0) m_done = 1'b1;
          else m_act = 1'b1;
        end else begin
          m_rem = 0;
        end
      end
    end
    #1;
    if (m_valid) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_act});
      chk("model_done", {31'd0, done}, {31'd0, m_done});
      chk("model_q", {24'd0, q}, m_rem);
    end
  end

  task automatic cyc(input bit s, input bit t, input bit a, input bit r, input logic [7:0] l);
    @(negedge clk);
    start = s; tick = t; abort = a; rst = r; load = l;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // Basic interval, ticks continuous, tick at acceptance not counted
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
    chk("basic_q3", {24'd0, q}, 32'd3);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("basic_q2", {24'd0, q}, 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("basic_q1", {24'd0, q}, 32'd1);
    chk("basic_nodone", {31'd0, done}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("basic_q0", {24'd0, q}, 32'd0);
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_busy_off", {31'd0, busy}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("basic_done_1cyc", {31'd0, done}, 32'd0);

    // Reset mid-interval
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("midrst_q3", {24'd0, q}, 32'd3);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    chk("midrst_q", {24'd0, q}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("midrst_nodone", {31'd0, done}, 32'd0);

    // Sparse ticks with an ignored restart carrying load 9
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 8; i++) begin
      cyc(i == 1, (i % 4) == 3, 1'b0, 1'b0, (i == 1) ? 8'd9 : 8'd0);
      if (i == 1) chk("sparse_ignore_start", {24'd0, q}, 32'd2);
      if (i == 3) chk("sparse_q1", {24'd0, q}, 32'd1);
      if (i == 6) chk("sparse_hold", {24'd0, q}, 32'd1);
      if (i == 7) chk("sparse_done", {31'd0, done}, 32'd1);
    end

    // Zero-length interval
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("zero_done_off", {31'd0, done}, 32'd0);

    // Maximum interval
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd255);
    chk("max_q", {24'd0, q}, 32'd255);
    repeat (254) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("max_q1", {24'd0, q}, 32'd1);
    chk("max_nodone", {31'd0, done}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("max_done", {31'd0, done}, 32'd1);
    chk("max_q0", {24'd0, q}, 32'd0);

    // Abort racing the final tick
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    chk("abort_q", {24'd0, q}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("abort_done_later", {31'd0, done}, 32'd0);

    // Back-to-back: start held through expiry is accepted in DONE
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    chk("b2b_done", {31'd0, done}, 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    chk("b2b_q", {24'd0, q}, 32'd2);
    chk("b2b_busy", {31'd0, busy}, 32'd1);

    // Randomized traffic, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 8) == 0,
          ($urandom % 2) == 0,
          ($urandom % 32) == 0,
          ($urandom % 128) == 0,
          (($urandom % 16) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
